div16_8: RTL and testbench

- Sequential 16-bit by 8-bit unsigned restoring divider; the inverse of the mul8 multiplier.
- Takes a 16-bit dividend (the multiplier's product width) and an 8-bit divisor, and returns a 16-bit quotient and an 8-bit remainder.
- Started by a rising edge on start input S, matching the 0->1 start convention of mul8.
- Sits beside mul8 in the arithmetic unit so products can be divided back into their factors.

---
 rtl/div16_8.sv | 129 ++++++++++++
 tb/tb_div16_8.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/div16_8.sv
// Sequential unsigned restoring divider (WN-bit dividend / WD-bit divisor),
// one quotient bit per clock, started by a rising edge on S.
module div16_8 #(
  parameter int unsigned WN = 16,
  parameter int unsigned WD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [WN-1:0] N,
  input  logic [WD-1:0] D,
  input  logic          S,
  output logic [WN-1:0] Q,
  output logic [WD-1:0] R,
  output logic          busy,
  output logic          done,
  output logic          dz
);

  localparam int unsigned CW = $clog2(WN);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic          s_q;
  logic          arm_q, arm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WN-1:0] sh_q, sh_d;
  logic [WD-1:0] dvs_q, dvs_d;
  logic [WD-1:0] rem_q, rem_d;
  logic [WN-1:0] q_q, q_d;
  logic [WD-1:0] r_q, r_d;
  logic          dz_q, dz_d;

  logic [WD:0]   rem9;
  logic          ge;
  logic [WD-1:0] rem_nx;
  logic [WN-1:0] sh_nx;
  logic          start_ok;

  // arm_q blocks a start until S has been seen low after reset, so S held
  // high through reset release cannot masquerade as a rising edge.
  assign start_ok = S & ~s_q & arm_q & (state_q != BUSY);

  always_comb begin
    rem9   = {rem_q, sh_q[WN-1]};
    ge     = (rem9 >= {1'b0, dvs_q});
    rem_nx = ge ? WD'(rem9 - {1'b0, dvs_q}) : rem9[WD-1:0];
    sh_nx  = {sh_q[WN-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q | ~S;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          sh_d    = N;
          dvs_d   = D;
          rem_d   = '0;
          cnt_d   = '0;
          dz_d    = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (dvs_q == '0) begin
          q_d     = '1;
          r_d     = '0;
          dz_d    = 1'b1;
          state_d = DONE;
        end else begin
          sh_d  = sh_nx;
          rem_d = rem_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WN - 1)) begin
            q_d     = sh_nx;
            r_d     = rem_nx;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      arm_q   <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= S;
      arm_q   <= arm_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign dz   = dz_q;

endmodule

// File: tb/tb_div16_8.sv
// Bench for div16_8: transaction-level model using / and %, checked every
// cycle, plus directed vectors with hand-computed literal results.
module tb_div16_8;

  logic        clk;
  logic        rst_n;
  logic [15:0] N;
  logic [7:0]  D;
  logic        S;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        busy, done, dz;

  int unsigned checks;
  int unsigned failures;
  bit          cmp_en;

  div16_8 #(.WN(16), .WD(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .N    (N),
    .D    (D),
    .S    (S),
    .Q    (Q),
    .R    (R),
    .busy (busy),
    .done (done),
    .dz   (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: a division takes 16 edges (1 edge for a zero divisor) and the
  // results come from plain integer division.
  logic        m_sq, m_arm, m_done, m_dz, p_dz;
  int unsigned m_cnt;
  logic [15:0] m_Q, p_Q;
  logic [7:0]  m_R, p_R;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sq <= 1'b0; m_arm <= 1'b0; m_cnt <= 0; m_done <= 1'b0;
      m_dz <= 1'b0; m_Q <= '0; m_R <= '0;
      p_Q <= '0; p_R <= '0; p_dz <= 1'b0;
    end else begin
      m_sq <= S;
      if (!S) m_arm <= 1'b1;
      if (S && !m_sq && m_arm && m_cnt == 0) begin
        m_cnt  <= (D == 0) ? 1 : 16;
        m_done <= 1'b0;
        m_dz   <= 1'b0;
        p_dz   <= (D == 0);
        p_Q    <= (D == 0) ? 16'hFFFF : 16'(N / D);
        p_R    <= (D == 0) ? 8'h00 : 8'(N % D);
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_Q    <= p_Q;
          m_R    <= p_R;
          m_dz   <= p_dz;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_Q", 32'(Q), 32'(m_Q));
      chk("cyc_R", 32'(R), 32'(m_R));
      chk("cyc_busy", 32'(busy), 32'(m_cnt != 0));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_dz", 32'(dz), 32'(m_dz));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int unsigned already, input int unsigned exp_lat, input string name);
    int unsigned n;
    n = already;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk(name, n, exp_lat);
  endtask

  // Raises S with new operands; the next edge is the accepting edge.
  task automatic run_div(input logic [15:0] n, input logic [7:0] d, input int unsigned lat,
                         input logic [15:0] eq, input logic [7:0] er, input string name);
    S = 1'b0;
    tick();
    N = n; D = d; S = 1'b1;
    tick();
    wait_done(0, lat, {name, "_lat"});
    chk({name, "_Q"}, 32'(Q), 32'(eq));
    chk({name, "_R"}, 32'(R), 32'(er));
    chk({name, "_dz"}, 32'(dz), 32'(d == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cmp_en = 1'b0;
    rst_n = 1'b1; S = 1'b0; N = '0; D = '0;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    chk("rst_Q", 32'(Q), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    run_div(16'd100, 8'd5, 16, 16'd20, 8'd0, "t100_5");
    run_div(16'd16, 8'd2, 16, 16'd8, 8'd0, "t16_2");
    for (int unsigned i = 0; i < 5; i++) tick();
    chk("held_S_done", 32'(done), 1);
    chk("held_S_busy", 32'(busy), 0);
    chk("held_S_Q", 32'(Q), 8);

    run_div(16'd1000, 8'd7, 16, 16'd142, 8'd6, "t1000_7");
    run_div(16'd65535, 8'd255, 16, 16'd257, 8'd0, "tmax_255");
    run_div(16'd65535, 8'd1, 16, 16'd65535, 8'd0, "tmax_1");
    run_div(16'd3, 8'd9, 16, 16'd0, 8'd3, "t3_9");
    run_div(16'd500, 8'd0, 1, 16'hFFFF, 8'd0, "t500_0");
    run_div(16'd0, 8'd37, 16, 16'd0, 8'd0, "t0_37");
    run_div(16'd43981, 8'd1, 16, 16'd43981, 8'd0, "tabcd_1");

    // Start pulse at edge 5 of a running division is ignored.
    S = 1'b0; tick();
    N = 16'd200; D = 8'd10; S = 1'b1;
    tick();
    S = 1'b0;
    for (int unsigned i = 0; i < 4; i++) tick();
    N = 16'd9; D = 8'd3; S = 1'b1;
    tick();
    S = 1'b0;
    wait_done(5, 16, "ign_lat");
    chk("ign_Q", 32'(Q), 20);
    chk("ign_R", 32'(R), 0);

    // Reset at edge 8 with S held high; S must fall and rise again.
    S = 1'b0; tick();
    N = 16'd200; D = 8'd10; S = 1'b1;
    tick();
    for (int unsigned i = 0; i < 8; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_Q", 32'(Q), 0);
    chk("abort_R", 32'(R), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_dz", 32'(dz), 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 4; i++) tick();
    chk("rel_busy", 32'(busy), 0);
    chk("rel_done", 32'(done), 0);
    run_div(16'd81, 8'd9, 16, 16'd9, 8'd0, "t81_9");

    S = 1'b0;
    tick(); tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
